wino_tile_sched: RTL and testbench

- Tile scheduler for the F(2x2,3x3) Winograd datapath: filter transform -> data transform -> element-wise multiply -> output transform.
- The datapath is free-running and has no stall; this block decides when it may start a tile.
- Walks the output map in 2x2-output tiles, row-major, and issues one 4x4 input-tile fetch per tile.
- Tracks each in-flight tile through a fixed-latency valid shift line and tags every datapath result with its tile coordinates.
- Issues a tile only while the downstream result buffer has a free slot (credit-based).

---
 rtl/wino_tile_sched_if.sv | 32 +++
 rtl/wino_tile_sched.sv | 173 +++++++++++++++++
 tb/tb_wino_tile_sched.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wino_tile_sched_if.sv
// Handshake/tag bundle between the Winograd tile scheduler and its frame
// controller, input buffer and result buffer.
interface wino_tile_sched_if #(
  parameter int CW = 8
);
  logic          start;
  logic [CW-1:0] cfg_tiles_h;
  logic [CW-1:0] cfg_tiles_w;
  logic          busy;
  logic          done;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_row;
  logic [CW-1:0] req_col;
  logic          res_valid;
  logic [CW-1:0] res_row;
  logic [CW-1:0] res_col;
  logic          res_last;
  logic          credit_ret;

  modport master (
    input  start, cfg_tiles_h, cfg_tiles_w, req_ready, credit_ret,
    output busy, done, req_valid, req_row, req_col,
           res_valid, res_row, res_col, res_last
  );

  modport slave (
    output start, cfg_tiles_h, cfg_tiles_w, req_ready, credit_ret,
    input  busy, done, req_valid, req_row, req_col,
           res_valid, res_row, res_col, res_last
  );
endinterface

// File: rtl/wino_tile_sched.sv
// F(2x2,3x3) Winograd tile scheduler: row-major tile issue under credit flow
// control, with a fixed-latency tag line. WINO_SCHED_PERF_EN adds perf counters.
module wino_tile_sched #(
  parameter int CW      = 8,
  parameter int LAT     = 6,
  parameter int CREDITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  wino_tile_sched_if.master  bus
`ifdef WINO_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stalls
`endif
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int         EW       = 2 * CW + 2;
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cfg_h_q, cfg_h_d, cfg_w_q, cfg_w_d;
  logic [CW-1:0]       row_q, row_d, col_q, col_d;
  logic [3:0]          cred_q, cred_d;
  logic [LAT-1:0][EW-1:0] line_q;
  logic [EW-1:0]       entry_s;
  logic                req_valid_s, issue_s, last_s, line_busy_s;

  assign req_valid_s = (state_q == S_RUN) && (cred_q != 4'd0);
  assign issue_s     = req_valid_s && bus.req_ready;
  assign last_s      = (row_q == cfg_h_q) && (col_q == cfg_w_q);
  assign entry_s     = issue_s ? {1'b1, last_s, row_q, col_q} : {EW{1'b0}};

  // Any tag still travelling toward the result port keeps DRAIN waiting.
  always_comb begin
    line_busy_s = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      line_busy_s = line_busy_s | line_q[i][EW-1];
    end
  end

  // Next state, configuration capture and tile walk.
  always_comb begin
    state_d = state_q;
    cfg_h_d = cfg_h_q;
    cfg_w_d = cfg_w_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cfg_h_d = bus.cfg_tiles_h;
          cfg_w_d = bus.cfg_tiles_w;
          row_d   = {CW{1'b0}};
          col_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue_s) begin
          if (last_s) begin
            state_d = S_DRAIN;
            row_d   = {CW{1'b0}};
            col_d   = {CW{1'b0}};
          end else if (col_q == cfg_w_q) begin
            col_d = {CW{1'b0}};
            row_d = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!line_busy_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Credits: one issue and one return may land together; returns saturate at full.
  always_comb begin
    cred_d = cred_q;
    if (issue_s && !bus.credit_ret) begin
      cred_d = cred_q - 4'd1;
    end else if (!issue_s && bus.credit_ret && (cred_q != CRED_MAX)) begin
      cred_d = cred_q + 4'd1;
    end else begin
      cred_d = cred_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_h_q <= {CW{1'b0}};
      cfg_w_q <= {CW{1'b0}};
      row_q   <= {CW{1'b0}};
      col_q   <= {CW{1'b0}};
      cred_q  <= CRED_MAX;
    end else begin
      state_q <= state_d;
      cfg_h_q <= cfg_h_d;
      cfg_w_q <= cfg_w_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cred_q  <= cred_d;
    end
  end

  // Tag line: the last stage lines up with the datapath Y output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q[0] <= entry_s;
      for (int i = 1; i < LAT; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.req_valid = req_valid_s;
  assign bus.req_row   = row_q;
  assign bus.req_col   = col_q;
  assign bus.res_valid = line_q[LAT-1][EW-1];
  assign bus.res_last  = line_q[LAT-1][EW-2];
  assign bus.res_row   = line_q[LAT-1][2*CW-1:CW];
  assign bus.res_col   = line_q[LAT-1][CW-1:0];

`ifdef WINO_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;
  logic        stall_s;

  assign stall_s = (state_q == S_RUN) &&
                   ((cred_q == 4'd0) || (req_valid_s && !bus.req_ready));

  // Saturating perf counters, cleared when a frame is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      if (bus.busy && (perf_cycles_q != 32'hFFFF_FFFF)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (stall_s && (perf_stalls_q != 32'hFFFF_FFFF)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_wino_tile_sched.sv
// Directed bench for wino_tile_sched (CW=8, LAT=6, CREDITS=4): a per-cycle
// vector table for a 2x2-tile frame plus hand-written multi-cycle sequences.
module tb_wino_tile_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  wino_tile_sched_if #(.CW(8)) bus();

`ifdef WINO_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
  wino_tile_sched #(.CW(8), .LAT(6), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls));
`else
  wino_tile_sched #(.CW(8), .LAT(6), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       start, rdy, cret;
    logic       busy, done, rv;
    logic [7:0] rr, rc;
    logic       sv;
    logic [7:0] sr, sc;
    logic       sl;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t v(input logic s, input logic r, input logic c,
                             input logic b, input logic d, input logic rv,
                             input logic [7:0] rr, input logic [7:0] rc,
                             input logic sv, input logic [7:0] sr,
                             input logic [7:0] sc, input logic sl);
    vec_t t;
    t.start = s;  t.rdy = r;  t.cret = c;
    t.busy = b;   t.done = d; t.rv = rv;
    t.rr = rr;    t.rc = rc;
    t.sv = sv;    t.sr = sr;  t.sc = sc; t.sl = sl;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_req_valid"}, bus.req_valid, 0);
    chk({nm, "_req_row"}, bus.req_row, 0);
    chk({nm, "_req_col"}, bus.req_col, 0);
    chk({nm, "_res_valid"}, bus.res_valid, 0);
    chk({nm, "_res_row"}, bus.res_row, 0);
    chk({nm, "_res_col"}, bus.res_col, 0);
    chk({nm, "_res_last"}, bus.res_last, 0);
  endtask

  // Ready and returns high until done; counts issues. Leaves inputs idle.
  task automatic finish_frame(input string nm, input int bound, output int niss);
    bit seen = 0;
    niss = 0;
    bus.req_ready  = 1'b1;
    bus.credit_ret = 1'b1;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (bus.req_valid) niss++;
      if (bus.done) seen = 1;
      next_cyc();
    end
    chk({nm, "_done_seen"}, seen, 1);
    bus.credit_ret = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] h, input logic [7:0] w);
    bus.cfg_tiles_h = h;
    bus.cfg_tiles_w = w;
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int niss, nres, ndone, nbusy, exp_iss, exp_res;
    bit held, seen;
    logic [7:0] prev_row, prev_col;
    logic pat [4];

    bus.start = 1'b0; bus.cfg_tiles_h = 8'd0; bus.cfg_tiles_w = 8'd0;
    bus.req_ready = 1'b0; bus.credit_ret = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    next_cyc();

    // ---------------- basic 2x2-tile frame, per-cycle table ----------------
    tbl[0]  = v(1,1,0, 0,0,0, 0,0, 0,0,0,0);
    tbl[1]  = v(0,1,0, 1,0,1, 0,0, 0,0,0,0);
    tbl[2]  = v(0,1,0, 1,0,1, 0,1, 0,0,0,0);
    tbl[3]  = v(0,1,0, 1,0,1, 1,0, 0,0,0,0);
    tbl[4]  = v(0,1,0, 1,0,1, 1,1, 0,0,0,0);
    tbl[5]  = v(0,1,0, 1,0,0, 0,0, 0,0,0,0);
    tbl[6]  = v(0,1,0, 1,0,0, 0,0, 0,0,0,0);
    tbl[7]  = v(0,1,1, 1,0,0, 0,0, 1,0,0,0);
    tbl[8]  = v(0,1,1, 1,0,0, 0,0, 1,0,1,0);
    tbl[9]  = v(0,1,1, 1,0,0, 0,0, 1,1,0,0);
    tbl[10] = v(0,1,1, 1,0,0, 0,0, 1,1,1,1);
    tbl[11] = v(0,1,0, 1,0,0, 0,0, 0,0,0,0);
    tbl[12] = v(0,1,0, 0,1,0, 0,0, 0,0,0,0);
    tbl[13] = v(0,1,0, 0,0,0, 0,0, 0,0,0,0);
    bus.cfg_tiles_h = 8'd1;
    bus.cfg_tiles_w = 8'd1;
    for (int i = 0; i < 14; i++) begin
      bus.start = tbl[i].start;
      bus.req_ready = tbl[i].rdy;
      bus.credit_ret = tbl[i].cret;
      @(negedge clk);
      chk($sformatf("basic%0d_busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("basic%0d_done", i), bus.done, tbl[i].done);
      chk($sformatf("basic%0d_req_valid", i), bus.req_valid, tbl[i].rv);
      if (tbl[i].rv) begin
        chk($sformatf("basic%0d_req_row", i), bus.req_row, tbl[i].rr);
        chk($sformatf("basic%0d_req_col", i), bus.req_col, tbl[i].rc);
      end
      chk($sformatf("basic%0d_res_valid", i), bus.res_valid, tbl[i].sv);
      if (tbl[i].sv) begin
        chk($sformatf("basic%0d_res_row", i), bus.res_row, tbl[i].sr);
        chk($sformatf("basic%0d_res_col", i), bus.res_col, tbl[i].sc);
        chk($sformatf("basic%0d_res_last", i), bus.res_last, tbl[i].sl);
      end
      next_cyc();
    end
    bus.credit_ret = 1'b0;

    // ---------------- credit stall, single return, simultaneous event ----------------
    bus.req_ready = 1'b1;
    pulse_start(8'd0, 8'd7);
    niss = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        chk("stall_req_col", bus.req_col, niss);
        niss++;
      end
      next_cyc();
    end
    chk("stall_issue_count", niss, 4);
    bus.credit_ret = 1'b1;
    @(negedge clk);
    chk("stall_still_blocked", bus.req_valid, 0);
    next_cyc();
    // credits=1: issue and return together
    @(negedge clk);
    chk("ret_one_issue_valid", bus.req_valid, 1);
    chk("ret_one_issue_col", bus.req_col, 4);
    next_cyc();
    bus.credit_ret = 1'b0;
    @(negedge clk);
    chk("simul_keeps_one_valid", bus.req_valid, 1);
    chk("simul_keeps_one_col", bus.req_col, 5);
    next_cyc();
    @(negedge clk);
    chk("simul_then_empty", bus.req_valid, 0);
    next_cyc();
    finish_frame("stall", 60, niss);
    chk("stall_tail_issues", niss, 2);
    repeat (3) next_cyc();

    // Returns at full must not push credits above 4.
    bus.credit_ret = 1'b1;
    repeat (3) next_cyc();
    bus.credit_ret = 1'b0;
    pulse_start(8'd0, 8'd7);
    niss = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_valid) niss++;
      next_cyc();
    end
    chk("sat_issue_count", niss, 4);
    finish_frame("sat", 60, niss);
    chk("sat_tail_issues", niss, 4);
    repeat (3) next_cyc();

    // ---------------- backpressure 1,0,0,1 ----------------
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pulse_start(8'd0, 8'd3);
    exp_iss = 0; exp_res = 0; held = 0; seen = 0;
    prev_row = 8'd0; prev_col = 8'd0;
    for (int k = 0; k < 100 && !seen; k++) begin
      bus.req_ready = pat[k % 4];
      @(negedge clk);
      bus.credit_ret = bus.res_valid;
      if (held) begin
        chk("bp_hold_valid", bus.req_valid, 1);
        chk("bp_hold_row", bus.req_row, prev_row);
        chk("bp_hold_col", bus.req_col, prev_col);
      end
      if (bus.req_valid && bus.req_ready) begin
        chk("bp_req_row", bus.req_row, 0);
        chk("bp_req_col", bus.req_col, exp_iss);
        exp_iss++;
      end
      held = bus.req_valid && !bus.req_ready;
      prev_row = bus.req_row;
      prev_col = bus.req_col;
      if (bus.res_valid) begin
        chk("bp_res_row", bus.res_row, 0);
        chk("bp_res_col", bus.res_col, exp_res);
        chk("bp_res_last", bus.res_last, (exp_res == 3) ? 1 : 0);
        exp_res++;
      end
      if (bus.done) seen = 1;
      next_cyc();
    end
    bus.credit_ret = 1'b0;
    chk("bp_done_seen", seen, 1);
    chk("bp_issue_count", exp_iss, 4);
    chk("bp_result_count", exp_res, 4);
    repeat (2) next_cyc();

    // ---------------- reset mid-frame ----------------
    bus.req_ready = 1'b1;
    pulse_start(8'd3, 8'd3);
    repeat (3) next_cyc();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    next_cyc();
    rst = 1'b0;
    nres = 0; ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.res_valid) nres++;
      if (bus.done) ndone++;
      next_cyc();
    end
    chk("midrst_no_result", nres, 0);
    chk("midrst_no_done", ndone, 0);
    pulse_start(8'd0, 8'd0);
    nres = 0; niss = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      bus.credit_ret = bus.res_valid;
      if (bus.req_valid && bus.req_ready) niss++;
      if (bus.res_valid) begin
        nres++;
        chk("single_res_last", bus.res_last, 1);
        chk("single_res_row", bus.res_row, 0);
        chk("single_res_col", bus.res_col, 0);
      end
      if (bus.done) seen = 1;
      next_cyc();
    end
    bus.credit_ret = 1'b0;
    chk("single_done_seen", seen, 1);
    chk("single_issue_count", niss, 1);
    chk("single_result_count", nres, 1);
    repeat (2) next_cyc();

`ifdef WINO_SCHED_PERF_EN
    // ---------------- perf counters: 2 credit-stall cycles ----------------
    pulse_start(8'd0, 8'd4);
    nbusy = 0; seen = 0;
    for (int k = 1; k < 60 && !seen; k++) begin
      bus.credit_ret = (k == 6) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        seen = 1;
        chk("perf_stalls", perf_stalls, 2);
        chk("perf_cycles_vs_busy", perf_cycles, nbusy);
        chk("perf_cycles_abs", perf_cycles, 14);
      end
      next_cyc();
    end
    bus.credit_ret = 1'b0;
    chk("perf_done_seen", seen, 1);
`else
    nbusy = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
